// File: rtl/div_pkg.sv
// Shared types and helpers for the radix-2 restoring divider.
package div_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int DIV_WIDTH = 32;

    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
        return ~v + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             fits_s;

    assign shifted_s = {rem, dividend_msb};
    // When the subtraction fits, the difference is below the divisor, so WIDTH bits hold it exactly.
    assign diff_s    = shifted_s[WIDTH-1:0] - divisor;
    assign fits_s    = (shifted_s >= {1'b0, divisor});

    // Select the kept difference or the restored shifted remainder.
    always_comb begin
        if (fits_s) begin
            rem_next = diff_s;
            q_bit    = 1'b1;
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            q_bit    = 1'b0;
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient} for HI/LO.
module div_radix2
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               valid,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(ITERS);

    div_state_t         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               busy_r;
    logic               valid_r;
    logic [2*WIDTH-1:0] result_r;

    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic               neg_q_s;
    logic               neg_r_s;
    logic [WIDTH-1:0]   rem_next_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   quo_next_s;
    logic [WIDTH-1:0]   q_fix_s;
    logic [WIDTH-1:0]   r_fix_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem_r),
        .dividend_msb (quo_r[WIDTH-1]),
        .divisor      (divisor_r),
        .rem_next     (rem_next_s),
        .q_bit        (q_bit_s)
    );

    // The dividend register doubles as the quotient register: bits leave at the top, quotient bits enter at the bottom.
    assign quo_next_s = {quo_r[WIDTH-2:0], q_bit_s};

    // Operand magnitudes and sign flags; a zero divisor keeps raw operands so remainder comes out equal to a.
    always_comb begin
        a_mag_s = a;
        b_mag_s = b;
        neg_q_s = 1'b0;
        neg_r_s = 1'b0;
        if (signed_div && (b != {WIDTH{1'b0}})) begin
            a_mag_s = a[WIDTH-1] ? twos_neg(a) : a;
            b_mag_s = b[WIDTH-1] ? twos_neg(b) : b;
            neg_q_s = a[WIDTH-1] ^ b[WIDTH-1];
            neg_r_s = a[WIDTH-1];
        end else begin
            a_mag_s = a;
            b_mag_s = b;
        end
    end

    // Sign correction applied to the final iteration's outputs.
    always_comb begin
        q_fix_s = quo_next_s;
        r_fix_s = rem_next_s;
        if (neg_q_r) begin
            q_fix_s = twos_neg(quo_next_s);
        end else begin
            q_fix_s = quo_next_s;
        end
        if (neg_r_r) begin
            r_fix_s = twos_neg(rem_next_s);
        end else begin
            r_fix_s = rem_next_s;
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            divisor_r <= '0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            result_r  <= '0;
        end else if (flush) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (start) begin
                        state_r   <= RUN;
                        busy_r    <= 1'b1;
                        cnt_r     <= '0;
                        rem_r     <= '0;
                        quo_r     <= a_mag_s;
                        divisor_r <= b_mag_s;
                        neg_q_r   <= neg_q_s;
                        neg_r_r   <= neg_r_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(ITERS - 1)) begin
                        state_r  <= DONE;
                        busy_r   <= 1'b0;
                        valid_r  <= 1'b1;
                        result_r <= {r_fix_s, q_fix_s};
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign valid  = valid_r;
    assign result = result_r;

endmodule

// File: tb/tb_div_radix2.sv
// Directed-vector bench for div_radix2: latency, signed/unsigned results, corner cases, flush and reset.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

    div_radix2 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .busy       (busy),
        .valid      (valid),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle, issue start there, then wait (bounded) for valid; lat counts cycles from the start cycle.
    task automatic run_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                           output logic [63:0] res, output int lat, output int busy_n);
        step();
        signed_div = sd;
        a          = av;
        b          = bv;
        start      = 1'b1;
        step();
        start  = 1'b0;
        lat    = 1;
        busy_n = 0;
        res    = 64'hDEAD_DEAD_DEAD_DEAD;
        while (valid !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            step();
            lat++;
        end
        if (valid === 1'b1) res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (result !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        logic [63:0] res; int lat; int bn;
        run_div(1'b0, 32'd100, 32'd7, res, lat, bn);
        total++; if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
        total++; if (bn !== 32) begin bad++; $display("FAIL divu_busy_cycles got=%0d want=32", bn); end
        total++; if (res !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7 got=%h want=%h", res, {32'd2, 32'd14}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL divu_busy_at_valid got=%b want=0", busy); end
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL divu_valid_pulse got=%b want=0", valid); end
    endtask

    task automatic test_signed();
        logic [63:0] res; int lat; int bn;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, res, lat, bn);
        total++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_m7_2 got=%h want=%h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, res, lat, bn);
        total++; if (res !== {32'h0000_0001, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_7_m2 got=%h want=%h", res, {32'h0000_0001, 32'hFFFF_FFFD}); end
        run_div(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, res, lat, bn);
        total++; if (res !== {32'hFFFF_FFFF, 32'h0000_0003}) begin bad++; $display("FAIL div_m7_m2 got=%h want=%h", res, {32'hFFFF_FFFF, 32'h0000_0003}); end
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, res, lat, bn);
        total++; if (res !== {32'h0000_0001, 32'h7FFF_FFFC}) begin bad++; $display("FAIL divu_big_2 got=%h want=%h", res, {32'h0000_0001, 32'h7FFF_FFFC}); end
    endtask

    task automatic test_overflow();
        logic [63:0] res; int lat; int bn;
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bn);
        total++; if (res !== {32'h0, 32'h8000_0000}) begin bad++; $display("FAIL div_overflow got=%h want=%h", res, {32'h0, 32'h8000_0000}); end
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, res, lat, bn);
        total++; if (res !== {32'h0, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divu_max_1 got=%h want=%h", res, {32'h0, 32'hFFFF_FFFF}); end
    endtask

    task automatic test_div_zero();
        logic [63:0] res; int lat; int bn;
        run_div(1'b0, 32'd5, 32'd0, res, lat, bn);
        total++; if (res !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL divu_by_zero got=%h want=%h", res, {32'd5, 32'hFFFF_FFFF}); end
        total++; if (lat !== 33) begin bad++; $display("FAIL divu_by_zero_latency got=%0d want=33", lat); end
        run_div(1'b1, 32'd5, 32'd0, res, lat, bn);
        total++; if (res !== {32'd5, 32'hFFFF_FFFF}) begin bad++; $display("FAIL div_by_zero got=%h want=%h", res, {32'd5, 32'hFFFF_FFFF}); end
        total++; if (lat !== 33) begin bad++; $display("FAIL div_by_zero_latency got=%0d want=33", lat); end
    endtask

    // Abort at T+10 via flush (use_rst=0) or rst (use_rst=1); then a fresh 9/3 issued at T+12.
    task automatic test_abort(input logic use_rst, input logic [63:0] want_hold);
        logic [63:0] res; int lat; int bn; int seen_valid;
        seen_valid = 0;
        step();
        signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (valid === 1'b1) seen_valid++;
            step();
        end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0;
        if (valid === 1'b1) seen_valid++;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort%0d_busy got=%b want=0", use_rst, busy); end
        total++; if (seen_valid !== 0) begin bad++; $display("FAIL abort%0d_no_valid got=%0d want=0", use_rst, seen_valid); end
        total++; if (result !== want_hold) begin bad++; $display("FAIL abort%0d_result got=%h want=%h", use_rst, result, want_hold); end
        run_div(1'b0, 32'd9, 32'd3, res, lat, bn);
        total++; if (lat !== 33) begin bad++; $display("FAIL abort%0d_restart_latency got=%0d want=33", use_rst, lat); end
        total++; if (res !== {32'd0, 32'd3}) begin bad++; $display("FAIL abort%0d_restart got=%h want=%h", use_rst, res, {32'd0, 32'd3}); end
    endtask

    task automatic test_flush_with_start();
        step();
        signed_div = 1'b0; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b want=0", busy); end
        step();
        total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_start_idle got=%b%b want=00", busy, valid); end
    endtask

    task automatic test_ignored_start_back_to_back();
        logic [63:0] res; int lat; int bn;
        step();
        signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        for (int i = 0; i < 4; i++) begin step(); lat++; end
        signed_div = 1'b1; a = 32'd9; b = 32'd3; start = 1'b1;
        step();
        lat++;
        start = 1'b0; a = 32'd0; b = 32'd0;
        while (valid !== 1'b1 && lat < 40) begin step(); lat++; end
        total++; if (lat !== 33) begin bad++; $display("FAIL ignored_start_latency got=%0d want=33", lat); end
        total++; if (result !== {32'd2, 32'd14}) begin bad++; $display("FAIL ignored_start_result got=%h want=%h", result, {32'd2, 32'd14}); end
        run_div(1'b0, 32'd1000, 32'd10, res, lat, bn);
        total++; if (lat !== 33) begin bad++; $display("FAIL back_to_back_latency got=%0d want=33", lat); end
        total++; if (res !== {32'd0, 32'd100}) begin bad++; $display("FAIL back_to_back_result got=%h want=%h", res, {32'd0, 32'd100}); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_overflow();
        test_div_zero();
        test_abort(1'b0, {32'd5, 32'hFFFF_FFFF});
        test_abort(1'b1, 64'd0);
        test_flush_with_start();
        test_ignored_start_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
